fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the decode/control block. Owns the program counter and issues word reads to instruction memory, which may have variable latency. Buffers returned instructions in a small FIFO and presents them to decode with their PC and PC+4 over a valid/ready handshake. Takes redirects (branch/jump targets) from execute and stops fetching on a halt (ebreak/trap).

Parameters:
RESET_ADDR, 32'h0000_0000, PC value after reset
BUF_DEPTH, 2, instruction FIFO entries (power of 2, >=2)

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  synchronous, active-high reset
o_imem_ren  out  1  instruction read request, one-cycle pulse per request
o_imem_raddr  out  32  request address, always {pc[31:2],2'b00}
i_imem_rvalid  in  1  read data valid, >=1 cycle after request, in order
i_imem_rdata  in  32  read data
o_inst_valid  out  1  FIFO head valid
o_inst  out  32  head instruction
o_inst_pc  out  32  head PC, unaligned bits preserved
o_nxt_pc  out  32  head PC + 4, modulo 2^32
i_inst_ready  in  1  decode consumes head when valid & ready
i_redirect  in  1  flush and restart at i_redirect_pc
i_redirect_pc  in  32  redirect target
i_halt  in  1  stop fetching permanently until reset
o_halted  out  1  high in HALT state

Behaviour:
- Reset: pc=RESET_ADDR, FIFO empty, outstanding=0, squash=0, state=RUN. All outputs 0 except o_imem_raddr={RESET_ADDR[31:2],2'b00}. Reset mid-transfer drops any in-flight response: an rvalid arriving after reset for a pre-reset request is ignored via squash=1 only if outstanding was set. Simplest compliant rule: outstanding and squash are cleared, and the memory model is reset together with this block.
- States:
  - RUN: normal fetching.
  - HALT: entered the cycle after i_halt=1. No requests, FIFO cleared, o_inst_valid=0, o_halted=1. Left only by i_rst.
- At most one outstanding request. Issue (o_imem_ren=1) when state=RUN, !i_redirect, !i_halt, (outstanding==0 or i_imem_rvalid), and fifo_count_next + 1 <= BUF_DEPTH, counting the slot freed by a consume in the same cycle.
- On issue: the request PC is tagged and pc <= pc+4. A 1-cycle memory sustains 1 instr/cycle.
- On i_imem_rvalid with squash=0: push {tagged pc, rdata}. Data is visible on o_inst* the next cycle (registered FIFO). Latency from request to o_inst_valid = mem latency + 1.
- Head is stable while o_inst_valid & !i_inst_ready.
- Redirect (RUN state): FIFO flushed the same edge; pc <= i_redirect_pc; no issue that cycle. If a request is outstanding and not returning this cycle, squash <= 1. The next rvalid is discarded and clears squash and outstanding. An rvalid in the redirect cycle itself is discarded. A consume in the redirect cycle is still a valid handoff.
- Misaligned redirect target: fetched at the aligned address; o_inst_pc keeps low bits so downstream flags the trap.
- i_halt and i_redirect in the same cycle: halt wins.
- PC wrap: 32'hFFFF_FFFC + 4 = 0, no flag.

Optional Feature:
FETCH_STATS_EN. When defined, adds outputs o_fetch_cnt[31:0] (accepted handoffs) and o_squash_cnt[31:0] (discarded responses plus flushed FIFO entries). Both reset to 0, wrap silently, and freeze in HALT. When undefined, these ports and their logic are absent.

Test Plan:
- Reset release, 1-cycle imem, ready=1: requests at 0,4,8,... on consecutive cycles; o_inst_valid first high 2 cycles after reset release with o_inst_pc=0, o_nxt_pc=4, then one instruction per cycle.
- Backpressure: ready=0 for 5 cycles: FIFO holds 2 entries (pc 0,4), no further o_imem_ren, head stable. Ready=1 resumes in order at pc 8.
- Redirect with 3-cycle imem while a request for pc 0x10 is outstanding: redirect_pc=0x100. The 0x10 response is discarded, the next request goes to 0x100, and the first valid output has o_inst_pc=0x100.
- Same-cycle halt+redirect: o_halted=1 next cycle, no further requests, o_inst_valid=0 until reset.
- Redirect to 0x202: o_imem_raddr=0x200, o_inst_pc=0x202, o_nxt_pc=0x206.
- Wrap: redirect to 0xFFFF_FFFC: o_nxt_pc=0, next request address 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Instruction-memory, decode handoff and control bundle for
//               the fetch stage. Signal names are as seen from fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    logic        o_imem_ren;
    logic [31:0] o_imem_raddr;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic [31:0] o_nxt_pc;
    logic        i_inst_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_halt;
    logic        o_halted;

    modport master (
        output o_imem_ren,
        output o_imem_raddr,
        input  i_imem_rvalid,
        input  i_imem_rdata,
        output o_inst_valid,
        output o_inst,
        output o_inst_pc,
        output o_nxt_pc,
        input  i_inst_ready,
        input  i_redirect,
        input  i_redirect_pc,
        input  i_halt,
        output o_halted
    );

    modport slave (
        input  o_imem_ren,
        input  o_imem_raddr,
        output i_imem_rvalid,
        output i_imem_rdata,
        input  o_inst_valid,
        input  o_inst,
        input  o_inst_pc,
        input  o_nxt_pc,
        output i_inst_ready,
        output i_redirect,
        output i_redirect_pc,
        output i_halt,
        input  o_halted
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : PC owner and instruction fetcher with a small in-order FIFO
//               towards decode. Optional counters under FETCH_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  wire logic    i_clk,
    input  wire logic    i_rst,
    fetch_unit_if.master if_bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]  o_fetch_cnt,
    output logic [31:0]  o_squash_cnt
`endif
);

    localparam int unsigned        c_ptr_w   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned        c_cnt_w   = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(BUF_DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t             r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_req_pc;
    logic               r_outstanding;
    logic               r_squash;
    logic               r_halted;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_cnt;
    logic [31:0]        r_buf_inst [BUF_DEPTH];
    logic [31:0]        r_buf_pc   [BUF_DEPTH];

    logic               w_run;
    logic               w_head_valid;
    logic               w_pop;
    logic               w_resp;
    logic               w_push;
    logic               w_issue;
    logic [c_cnt_w-1:0] w_cnt_next;

    // Responses are only meaningful while a request is in flight.
    assign w_run        = (r_state == S_RUN);
    assign w_head_valid = w_run && (r_cnt != '0);
    assign w_pop        = w_head_valid && if_bus.i_inst_ready;
    assign w_resp       = if_bus.i_imem_rvalid && r_outstanding;
    assign w_push       = w_run && w_resp && !r_squash
                          && !if_bus.i_redirect && !if_bus.i_halt;
    assign w_cnt_next   = r_cnt + (w_push ? c_cnt_one : '0) - (w_pop ? c_cnt_one : '0);

    // A new request must find a free slot once its response lands.
    assign w_issue = !i_rst && w_run && !if_bus.i_redirect && !if_bus.i_halt
                     && (!r_outstanding || w_resp) && (w_cnt_next < c_depth);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_RUN;
            r_pc          <= RESET_ADDR;
            r_req_pc      <= RESET_ADDR;
            r_outstanding <= 1'b0;
            r_squash      <= 1'b0;
            r_halted      <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (if_bus.i_halt) begin
                        r_state       <= S_HALT;
                        r_halted      <= 1'b1;
                        r_outstanding <= 1'b0;
                        r_squash      <= 1'b0;
                        r_wr_ptr      <= '0;
                        r_rd_ptr      <= '0;
                        r_cnt         <= '0;
                    end else if (if_bus.i_redirect) begin
                        r_pc          <= if_bus.i_redirect_pc;
                        r_outstanding <= r_outstanding && !w_resp;
                        r_squash      <= r_outstanding && !w_resp;
                        r_wr_ptr      <= '0;
                        r_rd_ptr      <= '0;
                        r_cnt         <= '0;
                    end else begin
                        if (w_issue) begin
                            r_pc          <= r_pc + 32'd4;
                            r_req_pc      <= r_pc;
                            r_outstanding <= 1'b1;
                        end else if (w_resp) begin
                            r_outstanding <= 1'b0;
                        end
                        if (w_resp) begin
                            r_squash <= 1'b0;
                        end
                        if (w_push) begin
                            r_wr_ptr <= r_wr_ptr + c_ptr_one;
                        end
                        if (w_pop) begin
                            r_rd_ptr <= r_rd_ptr + c_ptr_one;
                        end
                        r_cnt <= w_cnt_next;
                    end
                end
                S_HALT: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    // Storage carries no reset; occupancy alone qualifies the head.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_buf_inst[r_wr_ptr] <= if_bus.i_imem_rdata;
            r_buf_pc[r_wr_ptr]   <= r_req_pc;
        end
    end

    assign if_bus.o_imem_ren   = w_issue;
    assign if_bus.o_imem_raddr = {r_pc[31:2], 2'b00};
    assign if_bus.o_inst_valid = w_head_valid;
    assign if_bus.o_inst       = w_head_valid ? r_buf_inst[r_rd_ptr] : 32'd0;
    assign if_bus.o_inst_pc    = w_head_valid ? r_buf_pc[r_rd_ptr] : 32'd0;
    assign if_bus.o_nxt_pc     = w_head_valid ? (r_buf_pc[r_rd_ptr] + 32'd4) : 32'd0;
    assign if_bus.o_halted     = r_halted;

`ifdef FETCH_STATS_EN
    logic               w_discard;
    logic [c_cnt_w-1:0] w_flushed;

    // Flushed entries exclude the head handed off in the redirect cycle.
    assign w_discard = w_run && w_resp && !if_bus.i_halt
                       && (r_squash || if_bus.i_redirect);
    assign w_flushed = (w_run && if_bus.i_redirect && !if_bus.i_halt)
                       ? (r_cnt - (w_pop ? c_cnt_one : '0)) : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_fetch_cnt  <= 32'd0;
            o_squash_cnt <= 32'd0;
        end else if (w_run) begin
            o_fetch_cnt  <= o_fetch_cnt + 32'(w_pop);
            o_squash_cnt <= o_squash_cnt + 32'(w_discard) + 32'(w_flushed);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed bench for fetch_unit with a variable-latency memory
//               model and an expected-instruction scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } sb_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_ADDR (32'h0000_0000),
        .BUF_DEPTH  (2)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .if_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sb_t         sbq[$];
    int          lat;
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    bit          pend;
    bit          sq;
    logic [31:0] pend_pc;
    logic [31:0] exp_pc;
    logic        exp_halted;

    logic        s_ren;
    logic [31:0] s_raddr;
    logic        s_valid;
    logic [31:0] s_inst;
    logic [31:0] s_pc;
    logic [31:0] s_nxt;
    logic        s_halted;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs and memory at negedge, sample 1ns later.
    task automatic cyc(input logic rdy, input logic rdr, input logic [31:0] rpc, input logic hlt);
        logic resp;
        sb_t  e;
        bus.i_inst_ready  = rdy;
        bus.i_redirect    = rdr;
        bus.i_redirect_pc = rpc;
        bus.i_halt        = hlt;
        bus.i_imem_rvalid = 1'b0;
        bus.i_imem_rdata  = 32'd0;
        resp = 1'b0;
        if (!rst && mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                resp              = 1'b1;
                mem_busy          = 1'b0;
                bus.i_imem_rvalid = 1'b1;
                bus.i_imem_rdata  = mem_data(mem_addr);
            end
        end
        #1;
        s_ren    = bus.o_imem_ren;
        s_raddr  = bus.o_imem_raddr;
        s_valid  = bus.o_inst_valid;
        s_inst   = bus.o_inst;
        s_pc     = bus.o_inst_pc;
        s_nxt    = bus.o_nxt_pc;
        s_halted = bus.o_halted;
        if (!rst) begin
            chk("inst_valid", 32'(s_valid), 32'(sbq.size() != 0));
            chk("halted", 32'(s_halted), 32'(exp_halted));
            if (s_valid && rdy && sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("head_inst", s_inst, e.inst);
                chk("head_pc", s_pc, e.pc);
                chk("head_nxt", s_nxt, e.pc + 32'd4);
            end
            if (exp_halted || rdr || hlt) chk("ren_blocked", 32'(s_ren), 32'd0);
            if (!exp_halted) begin
                if (hlt) begin
                    sbq.delete();
                    pend = 1'b0;
                    sq   = 1'b0;
                end else if (rdr) begin
                    sbq.delete();
                    if (resp) pend = 1'b0;
                    sq     = pend;
                    exp_pc = rpc;
                end else if (resp) begin
                    pend = 1'b0;
                    if (sq) begin
                        sq = 1'b0;
                    end else begin
                        e.pc   = pend_pc;
                        e.inst = mem_data({pend_pc[31:2], 2'b00});
                        sbq.push_back(e);
                    end
                end
            end
            if (s_ren) begin
                chk("raddr", s_raddr, {exp_pc[31:2], 2'b00});
                chk("one_outstanding", 32'(mem_busy), 32'd0);
                pend     = 1'b1;
                pend_pc  = exp_pc;
                exp_pc   = exp_pc + 32'd4;
                mem_busy = 1'b1;
                mem_cnt  = lat;
                mem_addr = s_raddr;
            end
            if (hlt) exp_halted = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int l);
        rst = 1'b1;
        lat = l;
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        rst        = 1'b0;
        mem_busy   = 1'b0;
        pend       = 1'b0;
        sq         = 1'b0;
        exp_pc     = 32'd0;
        exp_halted = 1'b0;
        sbq.delete();
    endtask

    task automatic wait_ren(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc(1'b1, 1'b0, 32'd0, 1'b0);
            found = s_ren;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc(1'b1, 1'b0, 32'd0, 1'b0);
            found = s_valid;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.i_imem_rvalid = 1'b0;
        bus.i_imem_rdata  = 32'd0;
        bus.i_inst_ready  = 1'b0;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = 32'd0;
        bus.i_halt        = 1'b0;
        @(negedge clk);

        // Reset state, then streaming with a 1-cycle memory
        do_reset(1);
        chk("rst_ren", 32'(s_ren), 32'd0);
        chk("rst_raddr", s_raddr, 32'd0);
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_halted", 32'(s_halted), 32'd0);
        chk("rst_inst", s_inst, 32'd0);
        chk("rst_nxt", s_nxt, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("c0_ren", 32'(s_ren), 32'd1);
        chk("c0_raddr", s_raddr, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("c1_ren", 32'(s_ren), 32'd1);
        chk("c1_raddr", s_raddr, 32'd4);
        chk("c1_valid", 32'(s_valid), 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("c2_valid", 32'(s_valid), 32'd1);
        chk("c2_pc", s_pc, 32'd0);
        chk("c2_nxt", s_nxt, 32'd4);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 32'd0, 1'b0);
            n += int'(s_valid);
        end
        chk("throughput", 32'(n), 32'd5);

        // Backpressure: two entries held, no further requests, head stable
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 32'd0, 1'b0);
            if (i >= 2) begin
                chk("bp_ren", 32'(s_ren), 32'd0);
                chk("bp_head_pc", s_pc, 32'd0);
            end
        end
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("bp_resume_ren", 32'(s_ren), 32'd1);
        chk("bp_resume_raddr", s_raddr, 32'd8);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'd0, 1'b0);

        // Redirect over an outstanding 3-cycle request for 0x10
        do_reset(3);
        n = 0;
        for (int i = 0; i < 40 && n == 0; i++) begin
            cyc(1'b1, 1'b0, 32'd0, 1'b0);
            if (s_ren && s_raddr == 32'h10) n = 1;
        end
        chk("rd_req10_seen", 32'(n), 32'd1);
        cyc(1'b1, 1'b1, 32'h100, 1'b0);
        wait_ren("rd_ren_timeout");
        chk("rd_raddr", s_raddr, 32'h100);
        wait_valid("rd_valid_timeout");
        chk("rd_first_pc", s_pc, 32'h100);

        // Halt and redirect together: halt wins
        do_reset(1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'd0, 1'b0);
        cyc(1'b1, 1'b1, 32'h300, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 32'd0, 1'b0);
            chk("halt_ren", 32'(s_ren), 32'd0);
            chk("halt_valid", 32'(s_valid), 32'd0);
        end

        // Misaligned redirect target
        do_reset(1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'd0, 1'b0);
        cyc(1'b1, 1'b1, 32'h202, 1'b0);
        wait_ren("mis_ren_timeout");
        chk("mis_raddr", s_raddr, 32'h200);
        wait_valid("mis_valid_timeout");
        chk("mis_pc", s_pc, 32'h202);
        chk("mis_nxt", s_nxt, 32'h206);
        chk("mis_inst", s_inst, mem_data(32'h200));

        // PC wrap at the top of the address space
        do_reset(1);
        cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        wait_ren("wrap_ren1_timeout");
        chk("wrap_raddr1", s_raddr, 32'hFFFF_FFFC);
        wait_ren("wrap_ren2_timeout");
        chk("wrap_raddr2", s_raddr, 32'h0);
        wait_valid("wrap_valid_timeout");
        chk("wrap_pc", s_pc, 32'hFFFF_FFFC);
        chk("wrap_nxt", s_nxt, 32'h0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
